param_bin_counter: RTL and testbench
====================================

PARAM_BIN_COUNTER -- requirements
Module: param_bin_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits; legal range 1..32.
REQ-002 Parameter MAX_VALUE, default 2**WIDTH-1, terminal value of the count range 0..MAX_VALUE; legal range 1..2**WIDTH-1.
REQ-003 Parameter PRESCALE, default 1, number of enabled cycles per count step; legal range >=1.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-006 en  input  1  count enable; advances the prescaler when high.
REQ-007 up_dn  input  1  direction: 1 = count up, 0 = count down.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  value written to out on load.
REQ-010 out  output  WIDTH  registered count value.
REQ-011 tc  output  1  registered terminal-count pulse.

Function
REQ-012 Per-edge priority SHALL be: reset low > load high > en high > hold.
REQ-013 Load SHALL set out to load_val, or to MAX_VALUE if load_val > MAX_VALUE; prescaler cleared to 0; tc = 0.
REQ-014 With en high and no load, the prescaler SHALL increment; when it equals PRESCALE-1 it returns to 0 and a step occurs on that edge.
REQ-015 With PRESCALE = 1, a step SHALL occur on every enabled edge (no prescaler latency).
REQ-016 With en low, out, prescaler and direction effect SHALL hold; tc = 0.
REQ-017 Up step: out = MAX_VALUE -> 0 with tc = 1; otherwise out + 1 with tc = 0.
REQ-018 Down step: out = 0 -> MAX_VALUE with tc = 1; otherwise out - 1 with tc = 0.
REQ-019 tc SHALL be high for exactly one cycle, updated on the same edge as the wrapping out update; tc = 0 on any edge without a boundary step.
REQ-020 up_dn SHALL be sampled only on step edges; changes between steps have no other effect.
REQ-021 load and en high together SHALL perform the load only; no step, prescaler cleared.
REQ-022 Arithmetic SHALL be modulo MAX_VALUE+1; out never exceeds MAX_VALUE.

Reset
REQ-023 reset low at a rising edge SHALL set out = 0, tc = 0, prescaler = 0, overriding load and en.
REQ-024 Reset asserted mid-prescale or mid-count SHALL discard all progress; counting resumes from 0 on the first enabled edge after release.
REQ-025 Before the first reset edge, output values are undefined; the bench SHALL NOT check them.

Configuration
REQ-026 Macro COUNTER_SATURATE_EN defined: a boundary step holds out at MAX_VALUE (up) or 0 (down) instead of wrapping; tc = 1 on every such step attempt.
REQ-027 Macro COUNTER_SATURATE_EN undefined: wrap behaviour per REQ-017/REQ-018; no saturation logic present.

Verification
REQ-028 Defaults; reset low 2 cycles, then en = 1, up_dn = 1 for 260 cycles -> out 0,1,...,255,0,1,2,3; tc = 1 only on the 255->0 edge.
REQ-029 MAX_VALUE = 9, up_dn = 0 from reset -> out 0,9,8,...,0,9; tc = 1 on each 0->9 edge.
REQ-030 PRESCALE = 4, en = 1 -> out steps once per 4 edges; en low for 2 cycles mid-prescale -> step delayed exactly 2 cycles.
REQ-031 load = 1, en = 1, load_val = 8'hF0 -> out = 8'hF0, prescaler cleared; with MAX_VALUE = 100, load_val = 200 -> out = 100.
REQ-032 Count to 37, then reset low for 1 edge with load = 1 -> out = 0, tc = 0; next enabled edge -> out = 1.
REQ-033 COUNTER_SATURATE_EN defined, up count from 253 -> out 254,255,255,255; tc = 1 on each edge while out = 255 and a step is attempted.

Source files
------------

// File: rtl/param_bin_counter.sv
// Parameterised up/down binary counter with prescaler, synchronous load and terminal-count pulse.
// Define COUNTER_SATURATE_EN to hold at the range boundary instead of wrapping.
module param_bin_counter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_VALUE = (WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << WIDTH) - 32'd1),
   parameter int unsigned PRESCALE  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             tc
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [WIDTH-1:0] MAXV  = MAX_VALUE[WIDTH-1:0];
   localparam logic [PW-1:0]    PLAST = PW'(PRESCALE - 1);

   logic [PW-1:0]    presc;
   logic             presc_done;
   logic             at_bound;
   logic [WIDTH-1:0] step_val;

   assign presc_done = (PRESCALE == 1) || (presc == PLAST);

   // Next count value if a step happens this edge; at_bound marks a boundary step (tc source)
   always_comb begin
      at_bound = 1'b0;
      step_val = out;
      if (up_dn) begin
         at_bound = (out == MAXV);
`ifdef COUNTER_SATURATE_EN
         step_val = at_bound ? MAXV : out + 1'b1;
`else
         step_val = at_bound ? '0 : out + 1'b1;
`endif
      end else begin
         at_bound = (out == '0);
`ifdef COUNTER_SATURATE_EN
         step_val = at_bound ? '0 : out - 1'b1;
`else
         step_val = at_bound ? MAXV : out - 1'b1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out   <= '0;
         tc    <= 1'b0;
         presc <= '0;
      end else if (load) begin
         out   <= (load_val > MAXV) ? MAXV : load_val;
         tc    <= 1'b0;
         presc <= '0;
      end else if (en) begin
         if (presc_done) begin
            presc <= '0;
            out   <= step_val;
            tc    <= at_bound;
         end else begin
            presc <= presc + 1'b1;
            tc    <= 1'b0;
         end
      end else begin
         tc <= 1'b0;
      end
   end

endmodule

// File: tb/tb_param_bin_counter.sv
// Directed self-checking bench for param_bin_counter: four instances share one stimulus bus,
// each test resets and checks the instance whose parameters it exercises.
module tb_param_bin_counter;

`ifdef COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, en, up_dn, load;
   logic [7:0] load_val;

   logic [7:0] out_def, out_p4, out_m100;
   logic [3:0] out_m9;
   logic       tc_def, tc_p4, tc_m100, tc_m9;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   param_bin_counter u_def (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .out(out_def), .tc(tc_def));

   param_bin_counter #(.WIDTH(4), .MAX_VALUE(9)) u_m9 (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val[3:0]), .out(out_m9), .tc(tc_m9));

   param_bin_counter #(.PRESCALE(4)) u_p4 (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .out(out_p4), .tc(tc_p4));

   param_bin_counter #(.MAX_VALUE(100)) u_m100 (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .out(out_m100), .tc(tc_m100));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; en = 1'b0; load = 1'b0; up_dn = 1'b1; load_val = 8'h00;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (out_def !== 8'd0 || tc_def !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_def out=%0d tc=%0b expected out=0 tc=0", out_def, tc_def);
      end
      vectors++;
      if (out_p4 !== 8'd0 || tc_p4 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_p4 out=%0d tc=%0b expected out=0 tc=0", out_p4, tc_p4);
      end
   endtask

   task automatic test_wrap_up();
      int exp_out = 0;
      bit exp_tc;
      do_reset();
      en = 1'b1; up_dn = 1'b1;
      for (int i = 1; i <= 260; i++) begin
         tick();
         exp_tc = (exp_out == 255);
         exp_out = exp_tc ? (SAT ? 255 : 0) : exp_out + 1;
         vectors++;
         if (out_def !== 8'(exp_out) || tc_def !== exp_tc) begin
            miscompares++;
            $display("[TB] FAIL wrap_up edge=%0d out=%0d tc=%0b expected out=%0d tc=%0b",
                     i, out_def, tc_def, exp_out, exp_tc);
         end
      end
      en = 1'b0;
      tick();
      vectors++;
      if (out_def !== 8'(exp_out) || tc_def !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL hold out=%0d tc=%0b expected out=%0d tc=0", out_def, tc_def, exp_out);
      end
   endtask

   task automatic test_down_max9();
      int exp_out = 0;
      bit exp_tc;
      do_reset();
      en = 1'b1; up_dn = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         exp_tc = (exp_out == 0);
         exp_out = exp_tc ? (SAT ? 0 : 9) : exp_out - 1;
         vectors++;
         if (out_m9 !== 4'(exp_out) || tc_m9 !== exp_tc) begin
            miscompares++;
            $display("[TB] FAIL down_max9 edge=%0d out=%0d tc=%0b expected out=%0d tc=%0b",
                     i, out_m9, tc_m9, exp_out, exp_tc);
         end
      end
   endtask

   task automatic test_prescale();
      bit         en_seq  [12] = '{1,1,1,1,1,0,0,1,1,1,1,1};
      logic [7:0] exp_seq [12] = '{0,0,0,1,1,1,1,1,1,2,2,2};
      do_reset();
      up_dn = 1'b1;
      for (int i = 0; i < 12; i++) begin
         en = en_seq[i];
         tick();
         vectors++;
         if (out_p4 !== exp_seq[i] || tc_p4 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL prescale edge=%0d out=%0d tc=%0b expected out=%0d tc=0",
                     i + 1, out_p4, tc_p4, exp_seq[i]);
         end
      end
   endtask

   task automatic test_load();
      do_reset();
      en = 1'b1; up_dn = 1'b1;
      tick();
      tick();
      load = 1'b1; load_val = 8'hF0;
      tick();
      load = 1'b0;
      vectors++;
      if (out_def !== 8'hF0 || tc_def !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL load_def out=%0h tc=%0b expected out=f0 tc=0", out_def, tc_def);
      end
      vectors++;
      if (out_p4 !== 8'hF0) begin
         miscompares++;
         $display("[TB] FAIL load_p4 out=%0h expected f0", out_p4);
      end
      vectors++;
      if (out_m100 !== 8'd100) begin
         miscompares++;
         $display("[TB] FAIL load_clamp out=%0d expected 100", out_m100);
      end
      tick(); tick(); tick();
      vectors++;
      if (out_p4 !== 8'hF0) begin
         miscompares++;
         $display("[TB] FAIL load_presc_clear_a out=%0h expected f0", out_p4);
      end
      tick();
      vectors++;
      if (out_p4 !== 8'hF1) begin
         miscompares++;
         $display("[TB] FAIL load_presc_clear_b out=%0h expected f1", out_p4);
      end
      load = 1'b1; load_val = 8'd50;
      tick();
      load = 1'b0;
      vectors++;
      if (out_m100 !== 8'd50) begin
         miscompares++;
         $display("[TB] FAIL load_inrange out=%0d expected 50", out_m100);
      end
      load = 1'b1; load_val = 8'd100;
      tick();
      load = 1'b0;
      tick();
      vectors++;
      if (out_m100 !== (SAT ? 8'd100 : 8'd0) || tc_m100 !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL max100_bound out=%0d tc=%0b expected out=%0d tc=1",
                  out_m100, tc_m100, SAT ? 100 : 0);
      end
      tick();
      vectors++;
      if (out_m100 !== (SAT ? 8'd100 : 8'd1) || tc_m100 !== SAT) begin
         miscompares++;
         $display("[TB] FAIL max100_after out=%0d tc=%0b expected out=%0d tc=%0b",
                  out_m100, tc_m100, SAT ? 100 : 1, SAT);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      en = 1'b1; up_dn = 1'b1;
      repeat (37) tick();
      vectors++;
      if (out_def !== 8'd37 || out_p4 !== 8'd9) begin
         miscompares++;
         $display("[TB] FAIL count37 def=%0d p4=%0d expected def=37 p4=9", out_def, out_p4);
      end
      reset = 1'b0; load = 1'b1; load_val = 8'd55;
      tick();
      reset = 1'b1; load = 1'b0;
      vectors++;
      if (out_def !== 8'd0 || tc_def !== 1'b0 || out_p4 !== 8'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_over_load def=%0d tc=%0b p4=%0d expected 0 0 0",
                  out_def, tc_def, out_p4);
      end
      tick();
      vectors++;
      if (out_def !== 8'd1) begin
         miscompares++;
         $display("[TB] FAIL resume out=%0d expected 1", out_def);
      end
      tick(); tick();
      vectors++;
      if (out_p4 !== 8'd0) begin
         miscompares++;
         $display("[TB] FAIL p4_discard_a out=%0d expected 0", out_p4);
      end
      tick();
      vectors++;
      if (out_p4 !== 8'd1) begin
         miscompares++;
         $display("[TB] FAIL p4_discard_b out=%0d expected 1", out_p4);
      end
   endtask

   task automatic test_saturate();
      logic [7:0] exp_out [4];
      bit         exp_tc  [4];
      if (SAT) begin
         exp_out = '{254, 255, 255, 255}; exp_tc = '{0, 0, 1, 1};
      end else begin
         exp_out = '{254, 255, 0, 1};     exp_tc = '{0, 0, 1, 0};
      end
      do_reset();
      up_dn = 1'b1; load = 1'b1; load_val = 8'd253;
      tick();
      load = 1'b0; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (out_def !== exp_out[i] || tc_def !== exp_tc[i]) begin
            miscompares++;
            $display("[TB] FAIL boundary edge=%0d out=%0d tc=%0b expected out=%0d tc=%0b",
                     i + 1, out_def, tc_def, exp_out[i], exp_tc[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_wrap_up();
      test_down_max9();
      test_prescale();
      test_load();
      test_reset_mid();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
